// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, bus word types and
// the command/response payloads held inside apb_master.
package apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  write;
    addr_t addr;
    data_t wdata;
  } apb_cmd_t;

  typedef struct packed {
    data_t rdata;
    logic  slverr;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns read data / error status on a one-entry response
// slot. Optional ACCESS-phase timeout enabled by APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
`ifdef APB_MASTER_TIMEOUT_EN
  , output logic                rsp_timeout
`endif
);

  apb_state_t state_q, state_d;
  apb_cmd_t   cmd_q, cmd_d;
  apb_rsp_t   rsp_q, rsp_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       cmd_ready_q, cmd_ready_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_to_q, rsp_to_d;
`endif

  // Next-state, bus outputs and response slot.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_to_d    = rsp_to_q;
`endif

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_to_d    = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = addr_t'(cmd_addr);
          cmd_d.wdata = cmd_write ? data_t'(cmd_wdata) : '0;
          psel_d      = 1'b1;
          state_d     = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d  = 1'b1;
          rsp_d.slverr = PSLVERR;
          rsp_d.rdata  = (!cmd_q.write && !PSLVERR) ? data_t'(PRDATA) : '0;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          state_d      = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_to_d     = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_d.slverr = 1'b1;
          rsp_d.rdata  = '0;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          state_d      = IDLE;
          rsp_to_d     = 1'b1;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // Ready only when idle and the response slot is free.
    cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
  end

  // State and output registers; reset aborts any transfer and drops the slot.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_to_q    <= rsp_to_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_slverr = rsp_q.slverr;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = cmd_q.write;
  assign PADDR      = ADDR_WIDTH'(cmd_q.addr);
  assign PWDATA     = DATA_WIDTH'(cmd_q.wdata);
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_to_q;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; APB slave responses are driven by hand
// per step (slave memory behaves as MEM[i]=i, error above word 1023).
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
  logic        rsp_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
`ifdef APB_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef APB_MASTER_TIMEOUT_EN
    , .rsp_timeout(rsp_timeout)
`endif
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel_pen", 32'({PSEL, PENABLE}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    PRESETn = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Write addr 5, zero wait states
    offer(1'b1, 32'd5, 32'hDEAD_BEEF);
    PREADY = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'h1234_5678; cmd_addr = 32'd99;
    chk("wr_setup_sel_en", 32'({PSEL, PENABLE}), 32'b10);
    chk("wr_setup_paddr", PADDR, 32'd5);
    chk("wr_setup_pwrite", 32'(PWRITE), 32'd1);
    chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_access_sel_en", 32'({PSEL, PENABLE}), 32'b11);
    chk("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr_done_sel_en", 32'({PSEL, PENABLE}), 32'b00);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_slverr", 32'(rsp_slverr), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_idle_pwdata_hold", PWDATA, 32'hDEAD_BEEF);
    chk("wr_rsp_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_rsp_consumed", 32'(rsp_valid), 32'd0);
    chk("wr_ready_again", 32'(cmd_ready), 32'd1);

    // Read addr 7, PREADY delayed 3 cycles into ACCESS
    PREADY = 1'b0; PRDATA = 32'd7;
    offer(1'b0, 32'd7, 32'h5555_5555);
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_pwrite", 32'(PWRITE), 32'd0);
    chk("rd_setup_pwdata_zero", PWDATA, 32'd0);
    tick();
    chk("rd_access1", 32'({PSEL, PENABLE}), 32'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_access_wait", {PENABLE, rsp_valid, PADDR[29:0]}, {1'b1, 1'b0, 30'd7});
    end
    PREADY = 1'b1;
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'd7);
    chk("rd_rsp_slverr", 32'(rsp_slverr), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read addr 1024: slave errors, read data must be zeroed
    PSLVERR = 1'b1; PRDATA = 32'hBAD0_0000;
    offer(1'b0, 32'd1024, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("err_paddr", PADDR, 32'd1024);
    tick(); tick();
    chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("err_rsp_slverr", 32'(rsp_slverr), 32'd1);
    chk("err_rsp_rdata", rsp_rdata, 32'd0);

    // Response back-pressure blocks a new command
    PSLVERR = 1'b0;
    offer(1'b1, 32'd9, 32'h0000_0099);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_blocked", 32'({cmd_ready, PSEL, rsp_valid, rsp_slverr}), 32'b0011);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_released", 32'({cmd_ready, PSEL, rsp_valid}), 32'b100);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accept_setup", 32'({PSEL, PENABLE}), 32'b10);
    chk("bp_accept_paddr", PADDR, 32'd9);
    tick(); tick();
    chk("bp_rsp", 32'({rsp_valid, rsp_slverr}), 32'b10);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset asserted mid-ACCESS
    PREADY = 1'b0;
    offer(1'b0, 32'd2, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_in_access", 32'({PSEL, PENABLE}), 32'b11);
    PRESETn = 1'b0;
    #1;
    chk("abort_async", 32'({PSEL, PENABLE, rsp_valid, cmd_ready}), 32'b0000);
    tick();
    chk("abort_held", 32'({PSEL, PENABLE, rsp_valid}), 32'b000);
    PRESETn = 1'b1;
    tick();
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    PREADY = 1'b1;
    offer(1'b1, 32'd3, 32'h0000_0033);
    tick();
    cmd_valid = 1'b0;
    chk("rec_paddr", PADDR, 32'd3);
    chk("rec_pwdata", PWDATA, 32'h0000_0033);
    tick(); tick();
    chk("rec_rsp", 32'({rsp_valid, rsp_slverr, PSEL}), 32'b100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout after 8 ACCESS cycles with PREADY stuck low
    PREADY = 1'b0; PRDATA = 32'd4;
    offer(1'b0, 32'd4, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_waiting", 32'({PENABLE, rsp_valid}), 32'b10);
    end
    tick();
    chk("to_psel", 32'({PSEL, PENABLE}), 32'b00);
    chk("to_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'b111);
    chk("to_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_cleared", 32'({rsp_valid, rsp_timeout}), 32'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
